// File: rtl/icepic_lib_pkg.sv
// Shared icepic types and register-file address map.
// STATUS layout: [7] IRP, [6:5] RP1:RP0, [4:3] read as ones, [2:0] Z/DC/C.
package icepic_lib_pkg;

    typedef struct packed {
        logic z;
        logic dc;
        logic c;
    } status_t;

    localparam logic [6:0] ADDR_INDF      = 7'h00;
    localparam logic [6:0] ADDR_STATUS    = 7'h03;
    localparam logic [6:0] ADDR_FSR       = 7'h04;
    localparam logic [6:0] ADDR_PORT_BASE = 7'h05;
    localparam logic [6:0] ADDR_GPR_BASE  = 7'h0C;

    localparam logic [7:0] STATUS_RST = 8'h18;

    function automatic logic [7:0] status_pack(input logic [2:0] hi, input status_t lo);
        return {hi, 2'b11, lo};
    endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: output latch, TRIS (1 = input), and a 2-flop pin synchroniser.
module gpio_port #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             port_we_in,
    input  logic             tris_we_in,
    input  logic [WIDTH-1:0] wdata_in,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] port_rd_out,
    output logic [WIDTH-1:0] tris_out,
    output logic [WIDTH-1:0] latch_out,
    output logic [WIDTH-1:0] oe_out
);

    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] tris_q, tris_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        latch_d = port_we_in ? wdata_in : latch_q;
        tris_d  = tris_we_in ? wdata_in : tris_q;
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            latch_q <= '0;
            tris_q  <= '1;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            latch_q <= latch_d;
            tris_q  <= tris_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Input pins show the synchronised value, output pins show what we drive.
    assign port_rd_out = (tris_q & sync2_q) | (~tris_q & latch_q);
    assign tris_out    = tris_q;
    assign latch_out   = latch_q;
    assign oe_out      = ~tris_q;

endmodule

// File: rtl/reg_file_banked.sv
// Banked icepic register file with IRP/FSR indirect access and GPIO ports.
// Define ICEPIC_FSR_POSTINC_EN to add fsr_postinc_in (FSR post-increment on indirect access).
module reg_file_banked
    import icepic_lib_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int NUM_PORTS  = 2,
    parameter int PORT_WIDTH = 8
) (
    input  logic                              clk_in,
    input  logic                              reset_n_in,
    input  logic [7:0]                        addr_in,
    input  logic                              write_en_in,
    input  logic [7:0]                        d_in,
    input  status_t                           status_in,
    input  logic                              status_update_in,
`ifdef ICEPIC_FSR_POSTINC_EN
    input  logic                              fsr_postinc_in,
`endif
    input  logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_in,
    output logic [7:0]                        d_out,
    output status_t                           status_out,
    output logic [1:0]                        page_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_oe_out
);

    localparam logic [1:0] BANK_MASK = 2'(NUM_BANKS - 1);
    localparam int         GPR_AW    = $clog2(NUM_BANKS * 128);

    logic [7:0]  fsr_q, fsr_d;
    logic [2:0]  stat_hi_q, stat_hi_d;
    status_t     stat_lo_q, stat_lo_d;

    logic        indirect;
    logic [1:0]  eff_bank;
    logic [6:0]  eff_off;
    logic        wr_ok;
    logic [GPR_AW-1:0] gpr_addr;
    logic [7:0]  gpr_q [NUM_BANKS*128];

    logic [PORT_WIDTH-1:0] port_rd [NUM_PORTS];
    logic [PORT_WIDTH-1:0] tris_rd [NUM_PORTS];

    logic unused_addr_msb;
    assign unused_addr_msb = addr_in[7];

    // Bank bits beyond NUM_BANKS are masked off, so a single-bank build never reaches TRIS.
    always_comb begin
        indirect = (addr_in[6:0] == ADDR_INDF);
        if (indirect) begin
            eff_bank = {stat_hi_q[2], fsr_q[7]} & BANK_MASK;
            eff_off  = fsr_q[6:0];
        end else begin
            eff_bank = stat_hi_q[1:0] & BANK_MASK;
            eff_off  = addr_in[6:0];
        end
        wr_ok    = write_en_in && (eff_off != ADDR_INDF);
        gpr_addr = GPR_AW'({eff_bank, eff_off});
    end

    always_comb begin
        stat_hi_d = stat_hi_q;
        stat_lo_d = stat_lo_q;
        if (wr_ok && eff_off == ADDR_STATUS) begin
            stat_hi_d = d_in[7:5];
            stat_lo_d = status_update_in ? status_in : status_t'(d_in[2:0]);
        end else if (status_update_in) begin
            stat_lo_d = status_in;
        end

        fsr_d = fsr_q;
        if (wr_ok && eff_off == ADDR_FSR) begin
            fsr_d = d_in;
        end
`ifdef ICEPIC_FSR_POSTINC_EN
        else if (indirect && fsr_postinc_in) begin
            fsr_d = fsr_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stat_hi_q <= STATUS_RST[7:5];
            stat_lo_q <= status_t'(STATUS_RST[2:0]);
            fsr_q     <= 8'h00;
        end else begin
            stat_hi_q <= stat_hi_d;
            stat_lo_q <= stat_lo_d;
            fsr_q     <= fsr_d;
        end
    end

    // GPR contents are deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (reset_n_in && wr_ok && eff_off >= ADDR_GPR_BASE) begin
            gpr_q[gpr_addr] <= d_in;
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic port_we;
        logic tris_we;
        assign port_we = wr_ok && (eff_bank == 2'd0) && (eff_off == ADDR_PORT_BASE + 7'(k));
        assign tris_we = wr_ok && (eff_bank == 2'd1) && (eff_off == ADDR_PORT_BASE + 7'(k));

        gpio_port #(.WIDTH(PORT_WIDTH)) u_port (
            .clk_in      (clk_in),
            .reset_n_in  (reset_n_in),
            .port_we_in  (port_we),
            .tris_we_in  (tris_we),
            .wdata_in    (d_in[PORT_WIDTH-1:0]),
            .pin_in      (gpio_in[k*PORT_WIDTH +: PORT_WIDTH]),
            .port_rd_out (port_rd[k]),
            .tris_out    (tris_rd[k]),
            .latch_out   (gpio_out[k*PORT_WIDTH +: PORT_WIDTH]),
            .oe_out      (gpio_oe_out[k*PORT_WIDTH +: PORT_WIDTH])
        );
    end

    always_comb begin
        d_out = 8'h00;
        if (eff_off == ADDR_STATUS) begin
            d_out = status_pack(stat_hi_q, stat_lo_q);
        end else if (eff_off == ADDR_FSR) begin
            d_out = fsr_q;
        end else if (eff_off >= ADDR_GPR_BASE) begin
            d_out = gpr_q[gpr_addr];
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (eff_off == ADDR_PORT_BASE + 7'(k)) begin
                    if (eff_bank == 2'd0) d_out = 8'(port_rd[k]);
                    else if (eff_bank == 2'd1) d_out = 8'(tris_rd[k]);
                end
            end
        end
    end

    assign status_out = stat_lo_q;
    assign page_out   = stat_hi_q[1:0];

endmodule
